temporal_avgpool_stream: RTL and testbench

- Downstream of the spatial convolution stage.
- Consumes its feature-interleaved Q8.8 stream (C features per time step) and averages each feature over POOL consecutive time steps.
- Emits one feature-interleaved pooled vector every POOL time steps.
- Valid-only streaming (no backpressure), matching the upstream stage; feeds the next temporal/attention stage.

---
 rtl/temporal_avgpool_stream.sv | 99 +++++++++
 tb/tb_temporal_avgpool_stream.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/temporal_avgpool_stream.sv
// temporal_avgpool_stream: per-feature average over POOL time steps of a feature-interleaved Q8.8 stream.
// Optional piecewise-linear ELU on the input when AVGPOOL_ELU_EN is defined.
module temporal_avgpool_stream #(
    parameter int C      = 8,
    parameter int DATA_W = 16,
    parameter int POOL   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sync_clr,
    input  logic                     x_valid,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     p_valid,
    output logic signed [DATA_W-1:0] p_out,
    output logic [(C > 1 ? $clog2(C) : 1)-1:0] p_feat,
    output logic                     sat_flag
);
    localparam int TW    = $clog2(POOL);
    localparam int ACC_W = DATA_W + TW;
    localparam int FW    = C > 1 ? $clog2(C) : 1;

    if (POOL < 2 || (POOL & (POOL - 1)) != 0) begin : g_bad_pool
        $error("POOL must be a power of 2 and >= 2");
    end

    logic [FW-1:0]            feat_q, feat_d;
    logic [TW-1:0]            time_q, time_d;
    logic signed [ACC_W-1:0]  acc_q [C];
    logic                     p_valid_q;
    logic signed [DATA_W-1:0] p_out_q;
    logic [FW-1:0]            p_feat_q;
    logic                     sat_q;

    logic signed [DATA_W-1:0] x_act;
`ifdef AVGPOOL_ELU_EN
    localparam logic signed [DATA_W-1:0] NEG_ONE = DATA_W'(-256);
    logic signed [DATA_W-1:0] x_half;
    assign x_half = x_in >>> 1;
    assign x_act  = !x_in[DATA_W-1] ? x_in : (x_half < NEG_ONE ? NEG_ONE : x_half);
`else
    assign x_act = x_in;
`endif

    logic signed [ACC_W-1:0] s, sum, sh;
    logic [TW:0]             hi;
    logic                    ovf, feat_last, time_last, emit;
    logic signed [DATA_W-1:0] sat_val;

    always_comb begin
        s         = ACC_W'(x_act);
        sum       = acc_q[feat_q] + s;
        sh        = sum >>> TW;
        hi        = sh[ACC_W-1:DATA_W-1];
        // the shifted sum fits DATA_W only if its top TW+1 bits are all sign copies
        ovf       = |hi && !(&hi);
        sat_val   = !ovf ? sh[DATA_W-1:0] :
                    sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        feat_last = feat_q == FW'(C - 1);
        time_last = time_q == TW'(POOL - 1);
        emit      = x_valid && time_last;
        feat_d    = !x_valid ? feat_q : feat_last ? '0 : feat_q + 1'b1;
        time_d    = !(x_valid && feat_last) ? time_q : time_last ? '0 : time_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q    <= '0;
            time_q    <= '0;
            p_valid_q <= 1'b0;
            p_out_q   <= '0;
            p_feat_q  <= '0;
            sat_q     <= 1'b0;
            for (int i = 0; i < C; i++) acc_q[i] <= '0;
        end else if (sync_clr) begin
            feat_q    <= '0;
            time_q    <= '0;
            p_valid_q <= 1'b0;
            p_out_q   <= '0;
            p_feat_q  <= '0;
            sat_q     <= 1'b0;
            for (int i = 0; i < C; i++) acc_q[i] <= '0;
        end else begin
            feat_q    <= feat_d;
            time_q    <= time_d;
            p_valid_q <= emit;
            if (x_valid) acc_q[feat_q] <= time_q == '0 ? s : sum;
            if (emit) begin
                p_out_q  <= sat_val;
                p_feat_q <= feat_q;
                sat_q    <= sat_q | ovf;
            end
        end
    end

    assign p_valid  = p_valid_q;
    assign p_out    = p_out_q;
    assign p_feat   = p_feat_q;
    assign sat_flag = sat_q;
endmodule

// File: tb/tb_temporal_avgpool_stream.sv
// tb_temporal_avgpool_stream: scoreboard bench for temporal_avgpool_stream with C=2, POOL=4.
module tb_temporal_avgpool_stream;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sync_clr = 1'b0;
    logic              x_valid = 1'b0;
    logic signed [15:0] x_in = '0;
    logic              p_valid;
    logic signed [15:0] p_out;
    logic [0:0]        p_feat;
    logic              sat_flag;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    logic acc_prev = 1'b0;

    temporal_avgpool_stream #(.C(2), .DATA_W(16), .POOL(4)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .x_valid(x_valid), .x_in(x_in),
        .p_valid(p_valid), .p_out(p_out), .p_feat(p_feat), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) acc_prev <= rst_n && x_valid && !sync_clr;

    always @(negedge clk) begin
        if (rst_n && p_valid) begin
            chk("pulse_latency", acc_prev, 1);
            if (exp_q.size() < 2) chk("unexpected_pulse", exp_q.size(), 2);
            else begin
                chk("p_feat", p_feat, exp_q.pop_front());
                chk("p_out", p_out, exp_q.pop_front());
            end
        end
    end

    task automatic expect_out(input int f, input int v);
        exp_q.push_back(f);
        exp_q.push_back(v);
    endtask

    task automatic send(input int v, input bit gap);
        @(posedge clk); #1;
        x_valid = 1'b1;
        x_in = 16'(v);
        if (gap) begin
            @(posedge clk); #1;
            x_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            x_valid = 1'b0;
        end
    endtask

    task automatic window(input int a[4], input int b[4], input bit gap);
        for (int t = 0; t < 4; t++) begin
            send(a[t], gap);
            send(b[t], gap);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int ln, le;
`ifdef AVGPOOL_ELU_EN
        ln = -128; le = -1;
`else
        ln = -256; le = 0;
`endif
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_p_valid", p_valid, 0);
        chk("rst_p_out", p_out, 0);
        chk("rst_p_feat", p_feat, 0);
        chk("rst_sat", sat_flag, 0);

        expect_out(0, 640); expect_out(1, ln);
        window('{256, 512, 768, 1024}, '{-256, -256, -256, -256}, 1'b0);
        idle(3);
        drain("s1_drain");

        expect_out(0, -1); expect_out(1, 0);
        window('{-1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);
        idle(3);
        drain("floor_drain");

        expect_out(0, 640); expect_out(1, ln);
        window('{256, 512, 768, 1024}, '{-256, -256, -256, -256}, 1'b1);
        idle(3);
        drain("gap_drain");

        for (int i = 0; i < 5; i++) send(7 + i, 1'b0);
        @(posedge clk); #3;
        x_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_p_valid", p_valid, 0);
        chk("arst_p_out", p_out, 0);
        chk("arst_p_feat", p_feat, 0);
        chk("arst_sat", sat_flag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_out(0, 100); expect_out(1, 100);
        window('{100, 100, 100, 100}, '{100, 100, 100, 100}, 1'b0);
        idle(3);
        drain("arst_drain");

        expect_out(0, 10); expect_out(1, 10);
        window('{10, 10, 10, 10}, '{10, 10, 10, 10}, 1'b0);
        @(posedge clk); #1;
        x_valid = 1'b1; x_in = 16'sd999; sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0; x_valid = 1'b0;
        @(negedge clk);
        chk("sclr_p_valid", p_valid, 0);
        chk("sclr_p_out", p_out, 0);
        chk("sclr_p_feat", p_feat, 0);
        drain("sclr_pending");
        for (int i = 0; i < 5; i++) send(-50 + i, 1'b0);
        @(posedge clk); #1;
        x_valid = 1'b1; x_in = 16'sd5000; sync_clr = 1'b1;
        expect_out(0, 100); expect_out(1, 100);
        @(posedge clk); #1;
        sync_clr = 1'b0; x_valid = 1'b0;
        window('{100, 100, 100, 100}, '{100, 100, 100, 100}, 1'b0);
        idle(3);
        drain("sclr_drain");

        expect_out(0, 10); expect_out(1, 10);
        expect_out(0, 20); expect_out(1, 20);
        expect_out(0, 30); expect_out(1, 30);
        window('{10, 10, 10, 10}, '{10, 10, 10, 10}, 1'b0);
        window('{20, 20, 20, 20}, '{20, 20, 20, 20}, 1'b0);
        window('{30, 30, 30, 30}, '{30, 30, 30, 30}, 1'b0);
        idle(3);
        drain("wrap_drain");

`ifdef AVGPOOL_ELU_EN
        expect_out(0, -256); expect_out(1, -100);
`else
        expect_out(0, -1024); expect_out(1, -200);
`endif
        window('{-1024, -1024, -1024, -1024}, '{-200, -200, -200, -200}, 1'b0);
        idle(3);
        drain("elu_drain");

        expect_out(0, -32768); expect_out(1, 32767);
        window('{-32768, -32768, -32768, -32768}, '{32767, 32767, 32767, 32767}, 1'b1);
        idle(3);
        if (le == 0) drain("extreme_drain");
        else begin
            exp_q.delete();
            idle(1);
        end
        chk("sat_flag_end", sat_flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
